mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single data-memory write port and one read port between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Sits between core and memory block; latches one command, sequences the access, returns data/ack to the owner.
- Fixed LS priority with a starvation counter guaranteeing fetch progress.

Parameters:
- ADDR_W, 9, byte/word address width on both sides (matches memory port).
- STARVE_LIMIT, 4, consecutive LS grants allowed while IF is pending before IF is forced.
- CNT_W, 3, starvation counter width; must satisfy 2**CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: command accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched word
- ls_req  in  1  LS request, held until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_mode  in  3  access mode (BYTE/HALF_WORD/WORD/U_BYTE/U_HALF_WORD encodings)
- ls_addr  in  ADDR_W  LS address
- ls_wdata  in  32  store data
- ls_gnt  out  1  one-cycle pulse: command accepted
- ls_rvalid  out  1  one-cycle pulse: load data valid / store complete
- ls_rdata  out  32  load data (0 for stores)
- ls_err  out  1  qualifies ls_rvalid; only driven with MISALIGN_CHECK_EN
- m_we  out  1  memory write enable
- m_wm  out  3  memory write mode
- m_wa  out  ADDR_W  memory write address
- m_wd  out  32  memory write data
- m_rm  out  3  memory read mode
- m_ra  out  ADDR_W  memory read address
- m_rd  in  32  memory read data (combinational from m_ra/m_rm)

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, starve_cnt=0, all outputs 0, latched command cleared. Reset during ACCESS drops the access; a pending write is not committed, because m_we is low in the reset cycle.
- FSM: IDLE -> ACCESS -> RESP -> IDLE; one access per 3 cycles.
- IDLE: if any req, pick winner, latch {owner, we, mode, addr, wdata}, pulse winner's gnt, go ACCESS. Otherwise stay.
- Arbitration: LS wins if ls_req and not (if_req and starve_cnt==STARVE_LIMIT); else IF if if_req.
- starve_cnt: +1 on an LS grant while if_req=1; cleared on an IF grant or when if_req=0 in IDLE; saturates at STARVE_LIMIT.
- IF commands: we=0, mode=WORD.
- ACCESS: drive m_ra/m_rm (and for stores m_wa/m_wm/m_wd, m_we=1) from the latch. The write commits at the end-of-cycle edge. Capture m_rd into the response register (0 for stores). Go RESP.
- RESP: pulse the owner's rvalid with the response data; rdata holds until the next rvalid; m_we=0. Go IDLE.
- m_we is high only in ACCESS with latched we=1. m_ra/m_rm hold their last value when idle.
- gnt and rvalid are never asserted to both requesters in the same cycle.
- Requests arriving during ACCESS/RESP are ignored until IDLE. Dropping req before gnt is legal: no side effect.

Optional Feature:
- MISALIGN_CHECK_EN defined: in IDLE, a granted LS command whose address is misaligned for its mode (HALF_WORD/U_HALF_WORD with addr[0]=1, WORD with addr[1:0]!=0) skips the memory access. It still passes through ACCESS with m_we=0; in RESP, ls_rvalid=1, ls_err=1, ls_rdata=0.
- Undefined: ls_err tied to 0; no address check.

Decomposition:
- Shared package mem_pkg: access-mode constants (BYTE, HALF_WORD, WORD, U_BYTE, U_HALF_WORD), RAM size constants, arb_state_t enum {IDLE, ACCESS, RESP}, owner_t enum {OWN_IF, OWN_LS}.
- One natural sub-module: arb_pick (combinational priority and starvation decision, takes req bits and starve_cnt, outputs owner and grant_valid).

Test Plan:
- IF-only read: if_req=1, if_addr=0x010, memory word 0xDEADBEEF -> if_gnt at cycle 1, m_ra=0x010 at cycle 2, if_rvalid=1 with if_rdata=0xDEADBEEF at cycle 3, no ls_* pulses.
- LS store then load: store WORD 0x12345678 to 0x020, then load BYTE 0x020 -> m_we=1 for exactly one cycle; load returns ls_rdata=0x00000078.
- Simultaneous requests: if_req and ls_req both held -> LS granted 4 times, 5th grant to IF (starve_cnt=4), then LS again.
- Reset mid-access: assert rst_n=0 in the ACCESS cycle of a store of 0xAAAAAAAA to 0x030 -> memory unchanged, all outputs 0 next cycle, FSM IDLE.
- Request withdrawn: ls_req pulsed for 0 cycles while busy in RESP -> no ls_gnt, no m_we.
- MISALIGN_CHECK_EN: WORD load at 0x022 -> ls_rvalid=1, ls_err=1, ls_rdata=0, m_we never asserted; without the macro, ls_err stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter and its memory block.
// Holds the access-mode encodings, the RAM size constants, the arbiter
// state and owner enums, and the alignment helper used by the optional
// address check.
package mem_pkg;

    // Access-mode encodings shared by the core, the arbiter and the memory
    localparam logic [2:0] BYTE        = 3'b000;
    localparam logic [2:0] HALF_WORD   = 3'b001;
    localparam logic [2:0] WORD        = 3'b010;
    localparam logic [2:0] U_BYTE      = 3'b100;
    localparam logic [2:0] U_HALF_WORD = 3'b101;

    // Data RAM geometry (byte addressed)
    localparam int RAM_BYTES = 512;
    localparam int RAM_WORDS = RAM_BYTES / 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    // True when the low address bits do not match the natural alignment
    // of the access size. Byte accesses are always aligned.
    function automatic logic is_misaligned(input logic [2:0] mode,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (mode)
            HALF_WORD, U_HALF_WORD: mis = addr_lo[0];
            WORD:                   mis = (addr_lo != 2'b00);
            default:                mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection for the memory arbiter.
// The load/store unit has fixed priority, except that once the fetch side
// has been passed over STARVE_LIMIT times in a row it is forced through.
//
// Ports:
//   if_req      fetch request
//   ls_req      load/store request
//   starve_cnt  consecutive LS grants made while fetch was waiting
//   owner       winning requester (valid when grant_valid=1)
//   grant_valid at least one request is present
module arb_pick
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             if_req,
    input  logic             ls_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_t           owner,
    output logic             grant_valid
);

    logic if_forced;

    always_comb begin
        if_forced   = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_valid = if_req || ls_req;
        owner       = (ls_req && !if_forced) ? OWN_LS : OWN_IF;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory write port and one read port between the
// instruction fetch unit (read-only) and the load/store unit (read/write).
// One command is latched, driven to memory, and answered per three cycles;
// all outputs are registered.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr                  fetch command (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata       fetch accept pulse, data pulse, data
//   ls_req/ls_we/ls_mode/ls_addr/ls_wdata   load/store command
//   ls_gnt/ls_rvalid/ls_rdata/ls_err        LS accept, completion, data, error
//   m_we/m_wm/m_wa/m_wd             memory write port
//   m_rm/m_ra/m_rd                  memory read port (m_rd combinational)
//
// Build option: define MISALIGN_CHECK_EN to reject misaligned LS accesses
// with ls_err instead of performing them; otherwise ls_err is tied low.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 9,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [2:0]        ls_mode,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              ls_err,
    output logic              m_we,
    output logic [2:0]        m_wm,
    output logic [ADDR_W-1:0] m_wa,
    output logic [31:0]       m_wd,
    output logic [2:0]        m_rm,
    output logic [ADDR_W-1:0] m_ra,
    input  logic [31:0]       m_rd
);

    arb_state_t        state;
    logic [CNT_W-1:0]  starve_cnt;

    owner_t            cmd_owner;
    logic              cmd_we;
    logic [2:0]        cmd_mode;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              cmd_err;

    owner_t            pick_owner;
    logic              pick_valid;
    logic              pick_err;

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .starve_cnt  (starve_cnt),
        .owner       (pick_owner),
        .grant_valid (pick_valid)
    );

`ifdef MISALIGN_CHECK_EN
    // Misalignment is judged on the command as it is accepted, so the
    // latched error flag travels with the command through ACCESS and RESP.
    assign pick_err = (pick_owner == OWN_LS) && is_misaligned(ls_mode, ls_addr[1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ls_err <= 1'b0;
        end else begin
            ls_err <= (state == RESP) && (cmd_owner == OWN_LS) && cmd_err;
        end
    end
`else
    assign pick_err = 1'b0;
    assign ls_err   = 1'b0;
`endif

    // Main sequencer. Because every output is registered, each pulse shows
    // up one cycle after the state that produces it: gnt during ACCESS,
    // the memory command during RESP, and rvalid during the following IDLE
    // (where the next winner is already being chosen).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cmd_owner  <= OWN_IF;
            cmd_we     <= 1'b0;
            cmd_mode   <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_err    <= 1'b0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_gnt     <= 1'b0;
            ls_rvalid  <= 1'b0;
            ls_rdata   <= '0;
            m_we       <= 1'b0;
            m_wm       <= '0;
            m_wa       <= '0;
            m_wd       <= '0;
            m_rm       <= '0;
            m_ra       <= '0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cmd_owner <= pick_owner;
                        cmd_err   <= pick_err;
                        if (pick_owner == OWN_LS) begin
                            cmd_we    <= ls_we;
                            cmd_mode  <= ls_mode;
                            cmd_addr  <= ls_addr;
                            cmd_wdata <= ls_wdata;
                            ls_gnt    <= 1'b1;
                        end else begin
                            cmd_we    <= 1'b0;
                            cmd_mode  <= WORD;
                            cmd_addr  <= if_addr;
                            cmd_wdata <= '0;
                            if_gnt    <= 1'b1;
                        end
                        state <= ACCESS;
                    end

                    // Count how long fetch has been passed over; the
                    // picker only lets LS win below the limit, so the
                    // extra compare just guards the saturation.
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end else if (pick_owner == OWN_IF) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end

                ACCESS: begin
                    m_ra <= cmd_addr;
                    m_rm <= cmd_mode;
                    if (cmd_we && !cmd_err) begin
                        m_wa <= cmd_addr;
                        m_wm <= cmd_mode;
                        m_wd <= cmd_wdata;
                    end
                    m_we  <= cmd_we && !cmd_err;
                    state <= RESP;
                end

                RESP: begin
                    m_we <= 1'b0;
                    if (cmd_owner == OWN_LS) begin
                        ls_rvalid <= 1'b1;
                        ls_rdata  <= (cmd_we || cmd_err) ? 32'h0 : m_rd;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= m_rd;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
